// File: rtl/uart_pkg.sv
// Shared definitions for the UART serial path: state encoding, frame geometry, symbol timing.
// Optional even-parity bit is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t IDLE   = 3'd0;
  localparam uart_state_t START  = 3'd1;
  localparam uart_state_t DATA   = 3'd2;
  localparam uart_state_t PARITY = 3'd3;
  localparam uart_state_t STOP   = 3'd4;

  localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  function automatic int symbol_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Symbol timer: counts 0..SymbolEdgeTime-1 while enabled and pulses tick on the last count.
// restart forces the count back to 0 so a receiver can re-phase it mid-symbol.
module uart_baud_tick #(
  parameter int SymbolEdgeTime = 16
) (
  input  logic Clock,
  input  logic reset_n,
  input  logic restart,
  input  logic enable,
  output logic tick
);

  localparam int CW = (SymbolEdgeTime > 2) ? $clog2(SymbolEdgeTime) : 1;
  localparam logic [CW-1:0] LAST = CW'(SymbolEdgeTime - 1);

  logic [CW-1:0] r_count;
  logic          w_at_last;

  assign w_at_last = (r_count == LAST);

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (restart || !enable || w_at_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign tick = enable && w_at_last;

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 serializer with a one-byte holding register behind a valid/ready handshake.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int ClockFreq = 100_000_000,
  parameter int BaudRate  = 115_200
) (
  input  logic       Clock,
  input  logic       reset_n,
  input  logic [7:0] DataIn,
  input  logic       DataInValid,
  output logic       DataInReady,
  output logic       SerialOut,
  output logic       TxBusy
);

  localparam int SymbolEdgeTime = symbol_time(ClockFreq, BaudRate);
  localparam int BCW = $clog2(DATA_BITS);

  if (SymbolEdgeTime < 2) begin : g_bad_baud
    $error("uart_transmitter: ClockFreq/BaudRate must be at least 2");
  end

  uart_state_t          r_state;
  uart_state_t          w_next_state;
  logic                 r_hold_full;
  logic [DATA_BITS-1:0] r_hold_data;
  logic [DATA_BITS-1:0] r_shift;
  logic [BCW-1:0]       r_bit_cnt;
  logic                 w_tick;
  logic                 w_load;
  logic                 w_last_bit;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  // Drain the holding register from IDLE, or straight out of STOP for gapless frames.
  assign w_load     = r_hold_full && ((r_state == IDLE) || ((r_state == STOP) && w_tick));
  assign w_last_bit = (r_bit_cnt == BCW'(DATA_BITS - 1));

  uart_baud_tick #(
    .SymbolEdgeTime(SymbolEdgeTime)
  ) u_baud (
    .Clock  (Clock),
    .reset_n(reset_n),
    .restart(w_load),
    .enable (r_state != IDLE),
    .tick   (w_tick)
  );

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:   if (r_hold_full) w_next_state = START;
      START:  if (w_tick) w_next_state = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (w_tick && w_last_bit) w_next_state = PARITY;
      PARITY: if (w_tick) w_next_state = STOP;
`else
      DATA:   if (w_tick && w_last_bit) w_next_state = STOP;
`endif
      STOP:   if (w_tick) w_next_state = r_hold_full ? START : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    SerialOut = 1'b1;
    case (r_state)
      START:  SerialOut = 1'b0;
      DATA:   SerialOut = r_shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY: SerialOut = r_parity;
`endif
      default: SerialOut = 1'b1;
    endcase
    DataInReady = !r_hold_full;
    TxBusy      = (r_state != IDLE) || r_hold_full;
  end

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      if (w_load) begin
        r_hold_full <= 1'b0;
        r_shift     <= r_hold_data;
        r_bit_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
        r_parity    <= ^r_hold_data;
`endif
      end else if (DataInValid && !r_hold_full) begin
        r_hold_full <= 1'b1;
        r_hold_data <= DataIn;
      end
      if ((r_state == DATA) && w_tick) begin
        r_shift   <= r_shift >> 1;
        r_bit_cnt <= r_bit_cnt + BCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at 16 clocks per bit; frame length follows UART_TX_PARITY_EN.
module tb_uart_transmitter;

  localparam int BIT_CYC = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       Clock = 1'b0;
  logic       reset_n;
  logic [7:0] DataIn;
  logic       DataInValid;
  logic       DataInReady;
  logic       SerialOut;
  logic       TxBusy;

  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  uart_transmitter #(
    .ClockFreq(1600),
    .BaudRate (100)
  ) dut (
    .Clock      (Clock),
    .reset_n    (reset_n),
    .DataIn     (DataIn),
    .DataInValid(DataInValid),
    .DataInReady(DataInReady),
    .SerialOut  (SerialOut),
    .TxBusy     (TxBusy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level for frame bit idx: start, 8 data LSB-first, [parity], stop.
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == NBITS - 1) return 1'b1;
    return ^b;
  endfunction

  task automatic idle_check(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      chk($sformatf("%s serial c%0d", tag, c), SerialOut, 32'd1);
      chk($sformatf("%s ready c%0d", tag, c), DataInReady, 32'd1);
      chk($sformatf("%s busy c%0d", tag, c), TxBusy, 32'd0);
      @(negedge Clock);
    end
    $display("idle %s cycles=%0d total=%0d bad=%0d", tag, n, total, bad);
  endtask

  // Checks one frame cycle by cycle, starting at the negedge just after the start bit begins.
  task automatic run_frame(input logic [7:0] b, input int set_at, input logic [7:0] set_data,
                           input int clr_at, input int rdy_low_from);
    for (int c = 0; c < NBITS * BIT_CYC; c++) begin
      chk($sformatf("frame %02h line c%0d", b, c), SerialOut, 32'(exp_bit(b, c / BIT_CYC)));
      chk($sformatf("frame %02h busy c%0d", b, c), TxBusy, 32'd1);
      chk($sformatf("frame %02h ready c%0d", b, c), DataInReady,
          (rdy_low_from >= 0 && c >= rdy_low_from) ? 32'd0 : 32'd1);
      if (c == set_at) begin
        DataInValid = 1'b1;
        DataIn      = set_data;
      end
      if (c == clr_at) DataInValid = 1'b0;
      @(negedge Clock);
    end
    $display("frame byte=%02h cycles=%0d total=%0d bad=%0d", b, NBITS * BIT_CYC, total, bad);
  endtask

  task automatic send_single(input logic [7:0] b);
    DataIn      = b;
    DataInValid = 1'b1;
    @(negedge Clock);
    DataInValid = 1'b0;
    chk($sformatf("hs %02h ready", b), DataInReady, 32'd0);
    chk($sformatf("hs %02h busy", b), TxBusy, 32'd1);
    chk($sformatf("hs %02h serial", b), SerialOut, 32'd1);
    @(negedge Clock);
    run_frame(b, -1, 8'h00, -1, -1);
    idle_check(4, $sformatf("after %02h", b));
  endtask

  initial begin
    reset_n     = 1'b0;
    DataIn      = 8'h00;
    DataInValid = 1'b0;
    #1;
    chk("rst serial", SerialOut, 32'd1);
    chk("rst ready", DataInReady, 32'd1);
    chk("rst busy", TxBusy, 32'd0);
    repeat (3) @(negedge Clock);
    reset_n = 1'b1;
    idle_check(200, "post-reset");

    send_single(8'h55);

    // Back-to-back: second byte queued during data bit 1 of the first frame
    DataIn      = 8'hA3;
    DataInValid = 1'b1;
    @(negedge Clock);
    DataInValid = 1'b0;
    chk("b2b hs ready", DataInReady, 32'd0);
    @(negedge Clock);
    run_frame(8'hA3, 40, 8'h0F, 41, 41);
    run_frame(8'h0F, -1, 8'h00, -1, -1);
    idle_check(4, "after b2b");

    // Backpressure: valid held high, source advances only after each acceptance
    DataIn      = 8'hFF;
    DataInValid = 1'b1;
    @(negedge Clock);
    chk("bp hs ready", DataInReady, 32'd0);
    DataIn = 8'h00;
    @(negedge Clock);
    run_frame(8'hFF, 1, 8'h81, -1, 1);
    run_frame(8'h00, -1, 8'h00, 1, 1);
    run_frame(8'h81, -1, 8'h00, -1, -1);
    idle_check(40, "after bp");

    // Reset during data bit 3 of 0xC6 with 0x12 queued
    DataIn      = 8'hC6;
    DataInValid = 1'b1;
    @(negedge Clock);
    DataInValid = 1'b0;
    @(negedge Clock);
    chk("mid start bit", SerialOut, 32'd0);
    DataIn      = 8'h12;
    DataInValid = 1'b1;
    @(negedge Clock);
    DataInValid = 1'b0;
    chk("mid queued ready", DataInReady, 32'd0);
    repeat (69) @(negedge Clock);
    chk("mid data bit3", SerialOut, 32'd0);
    chk("mid busy", TxBusy, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid async serial", SerialOut, 32'd1);
    chk("mid async busy", TxBusy, 32'd0);
    chk("mid async ready", DataInReady, 32'd1);
    repeat (2) @(negedge Clock);
    reset_n = 1'b1;
    idle_check(200, "after mid reset");
    $display("reset mid-frame done total=%0d bad=%0d", total, bad);

    send_single(8'h07);
    send_single(8'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
